// File: rtl/sdram_fifo_pkg.sv
// Shared constants for the SDRAM-backed FIFO front-end: one-hot FSM state
// encodings, default geometry and the linear-pointer width helper.
package sdram_fifo_pkg;

   localparam logic [2:0] IDLE     = 3'b001;
   localparam logic [2:0] WR_BURST = 3'b010;
   localparam logic [2:0] RD_BURST = 3'b100;

   localparam int DSIZE_DEF    = 16;
   localparam int ASIZE_DEF    = 13;
   localparam int BSIZE_DEF    = 2;
   localparam int COL_BITS_DEF = 9;

   // Linear word pointer width: {wrap, bank, row, col}.
   function automatic int ptr_width(input int bsize, input int asize, input int col_bits);
      return bsize + asize + col_bits + 1;
   endfunction

endpackage

// File: rtl/sdram_fifo_ctrl_fifo.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO. The head word is
// combinational on dout; pushes while full and pops while empty are ignored.
// When empty, dout keeps showing the most recently popped word.
module sync_fifo_fwft #(
   parameter int DSIZE   = 16,
   parameter int FIFO_AW = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [DSIZE-1:0] din,
   output logic [DSIZE-1:0] dout,
   output logic [FIFO_AW:0] count,
   output logic             full,
   output logic             empty
);

   localparam int CW = FIFO_AW + 1;
   localparam logic [FIFO_AW:0] DEPTH = CW'(2 ** FIFO_AW);

   logic [DSIZE-1:0]   mem [2**FIFO_AW];
   logic [FIFO_AW-1:0] wp_q, wp_d, rp_q, rp_d, rp_last;
   logic [FIFO_AW:0]   cnt_q, cnt_d;
   logic               do_push, do_pop;

   assign full    = (cnt_q == DEPTH);
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign rp_last = rp_q - 1'b1;
   assign dout    = empty ? mem[rp_last] : mem[rp_q];

   // Pointer and occupancy next-state; simultaneous push and pop keep the count.
   always_comb begin
      do_push = push && !full;
      do_pop  = pop && !empty;
      wp_d    = wp_q;
      rp_d    = rp_q;
      cnt_d   = cnt_q;
      if (do_push) wp_d = wp_q + 1'b1;
      if (do_pop)  rp_d = rp_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
   end

   // Storage array, written on accepted pushes only (no reset on data).
   always_ff @(posedge clk) begin
      if (do_push) mem[wp_q] <= din;
   end

   // Control state with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sdram_fifo_ctrl.sv
// sdram_fifo_ctrl: user streaming FIFO front-end that stages writes in a local
// FIFO, moves them to SDRAM in fixed bursts, prefetches bursts back into a
// local read FIFO, and so behaves as one large FIFO backed by SDRAM.
// Optional macro SDRAM_FIFO_ERR_EN enables the sticky err_ovf/err_udf flags.
module sdram_fifo_ctrl
   import sdram_fifo_pkg::*;
#(
   parameter int DSIZE     = DSIZE_DEF,
   parameter int ASIZE     = ASIZE_DEF,
   parameter int BSIZE     = BSIZE_DEF,
   parameter int COL_BITS  = COL_BITS_DEF,
   parameter int BURST_LEN = 8,
   parameter int FIFO_AW   = 9
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             wr_en,
   input  logic [DSIZE-1:0] wr_data,
   output logic             wr_full,
   input  logic             rd_en,
   output logic [DSIZE-1:0] rd_data,
   output logic             rd_empty,
   output logic             Wr,
   output logic             Rd,
   output logic [BSIZE-1:0] Baddr,
   output logic [ASIZE-1:0] Raddr,
   output logic [ASIZE-1:0] Caddr,
   output logic [DSIZE-1:0] Wr_data,
   input  logic             Wr_data_vaild,
   input  logic             Wdata_done,
   input  logic [DSIZE-1:0] Rd_data,
   input  logic             Rd_data_vaild,
   input  logic             Rdata_done,
   output logic             err_ovf,
   output logic             err_udf
);

   localparam int N  = ptr_width(BSIZE, ASIZE, COL_BITS);
   localparam int CW = FIFO_AW + 1;
   localparam logic [N-1:0]   BL_PTR     = N'(BURST_LEN);
   localparam logic [N-1:0]   FULL_LIM   = N'((2 ** (N - 1)) - BURST_LEN);
   localparam logic [CW-1:0]  BL_CNT     = CW'(BURST_LEN);
   localparam logic [CW-1:0]  RD_RESERVE = CW'(BURST_LEN + 1);
   localparam logic [CW-1:0]  DEPTH      = CW'(2 ** FIFO_AW);

   logic [2:0]       state_q, state_d;
   logic [N-1:0]     wptr_q, wptr_d, rptr_q, rptr_d, sd_level;
   logic [BSIZE-1:0] baddr_q, baddr_d;
   logic [ASIZE-1:0] raddr_q, raddr_d, caddr_q, caddr_d;
   logic [CW-1:0]    wf_count, rf_count, rf_free;
   logic             wf_full, wf_empty, rf_full, rf_empty;
   logic             sd_full, wr_go, rd_go;

   // Write staging FIFO: user pushes, controller pops as it takes burst words.
   sync_fifo_fwft #(.DSIZE(DSIZE), .FIFO_AW(FIFO_AW)) u_wr_fifo (
      .clk(Clk), .rst(Rst),
      .push(wr_en && !wf_full), .pop(Wr_data_vaild && !wf_empty),
      .din(wr_data), .dout(Wr_data), .count(wf_count),
      .full(wf_full), .empty(wf_empty)
   );

   // Read prefetch FIFO: SDRAM words pushed in, user pops.
   sync_fifo_fwft #(.DSIZE(DSIZE), .FIFO_AW(FIFO_AW)) u_rd_fifo (
      .clk(Clk), .rst(Rst),
      .push(Rd_data_vaild && !rf_full), .pop(rd_en && !rf_empty),
      .din(Rd_data), .dout(rd_data), .count(rf_count),
      .full(rf_full), .empty(rf_empty)
   );

   assign wr_full  = wf_full;
   assign rd_empty = rf_empty;
   assign sd_level = wptr_q - rptr_q;
   assign sd_full  = (sd_level > FULL_LIM);
   assign rf_free  = DEPTH - rf_count;
   // A read is only launched when the whole burst is guaranteed room.
   assign wr_go    = (wf_count >= BL_CNT) && !sd_full;
   assign rd_go    = (sd_level >= BL_PTR) && (rf_free >= RD_RESERVE);

   assign Wr    = (state_q == WR_BURST);
   assign Rd    = (state_q == RD_BURST);
   assign Baddr = baddr_q;
   assign Raddr = raddr_q;
   assign Caddr = caddr_q;

   // Burst scheduler: writes have priority, every burst returns through IDLE.
   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      baddr_d = baddr_q;
      raddr_d = raddr_q;
      caddr_d = caddr_q;
      case (state_q)
         IDLE: begin
            if (wr_go) begin
               state_d = WR_BURST;
               baddr_d = wptr_q[COL_BITS+ASIZE +: BSIZE];
               raddr_d = wptr_q[COL_BITS +: ASIZE];
               caddr_d = ASIZE'(wptr_q[COL_BITS-1:0]);
            end else if (rd_go) begin
               state_d = RD_BURST;
               baddr_d = rptr_q[COL_BITS+ASIZE +: BSIZE];
               raddr_d = rptr_q[COL_BITS +: ASIZE];
               caddr_d = ASIZE'(rptr_q[COL_BITS-1:0]);
            end
         end
         WR_BURST: begin
            if (Wdata_done) begin
               state_d = IDLE;
               wptr_d  = wptr_q + BL_PTR;
            end
         end
         RD_BURST: begin
            if (Rdata_done) begin
               state_d = IDLE;
               rptr_d  = rptr_q + BL_PTR;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Scheduler state, SDRAM pointers and latched burst address.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         baddr_q <= '0;
         raddr_q <= '0;
         caddr_q <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         baddr_q <= baddr_d;
         raddr_q <= raddr_d;
         caddr_q <= caddr_d;
      end
   end

`ifdef SDRAM_FIFO_ERR_EN
   logic err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;

   // Sticky misuse flags; only reset clears them.
   always_comb begin
      err_ovf_d = err_ovf_q | (wr_en & wf_full) | (Rd_data_vaild & rf_full);
      err_udf_d = err_udf_q | (rd_en & rf_empty) | (Wr_data_vaild & wf_empty);
   end

   // Error flag registers.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         err_ovf_q <= 1'b0;
         err_udf_q <= 1'b0;
      end else begin
         err_ovf_q <= err_ovf_d;
         err_udf_q <= err_udf_d;
      end
   end

   assign err_ovf = err_ovf_q;
   assign err_udf = err_udf_q;
`else
   assign err_ovf = 1'b0;
   assign err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_fifo_ctrl.sv
// Bench for sdram_fifo_ctrl: an SDRAM controller model answers bursts, and a
// queue of pushed words is the reference for everything the user pops.
module tb_sdram_fifo_ctrl;

   logic        clk;
   logic        Rst;
   logic        wr_en, rd_en;
   logic [15:0] wr_data, rd_data;
   logic        wr_full, rd_empty;
   logic        Wr, Rd;
   logic [1:0]  Baddr;
   logic [12:0] Raddr, Caddr;
   logic [15:0] Wr_data, Rd_data;
   logic        Wr_data_vaild, Wdata_done, Rd_data_vaild, Rdata_done;
   logic        err_ovf, err_udf;

   typedef struct {
      bit wr;
      int b;
      int r;
      int c;
   } burst_t;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];
   burst_t      blog[$];
   int          exp_wptr = 0;
   int          exp_rptr = 0;
   int          both_seen = 0;
   logic [15:0] sdram_mem [int];

`ifdef SDRAM_FIFO_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   sdram_fifo_ctrl dut (
      .Clk(clk), .Rst(Rst),
      .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
      .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
      .Wr(Wr), .Rd(Rd), .Baddr(Baddr), .Raddr(Raddr), .Caddr(Caddr),
      .Wr_data(Wr_data), .Wr_data_vaild(Wr_data_vaild), .Wdata_done(Wdata_done),
      .Rd_data(Rd_data), .Rd_data_vaild(Rd_data_vaild), .Rdata_done(Rdata_done),
      .err_ovf(err_ovf), .err_udf(err_udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // SDRAM controller model: streams 8 words per burst, then pulses done.
   initial begin : ctl_model
      int st, cnt, base, lin;
      burst_t e;
      st = 0; cnt = 0; base = 0;
      Wr_data_vaild = 0; Wdata_done = 0; Rd_data_vaild = 0; Rdata_done = 0; Rd_data = '0;
      forever begin
         @(negedge clk);
         if (Wr && Rd) both_seen++;
         if (Rst) begin
            st = 0;
            Wr_data_vaild = 0; Wdata_done = 0; Rd_data_vaild = 0; Rdata_done = 0;
         end else begin
            Wdata_done = 0;
            Rdata_done = 0;
            lin = (int'(Baddr) << 22) | (int'(Raddr) << 9) | int'(Caddr[8:0]);
            if (st == 0 && (Wr || Rd)) begin
               e.wr = Wr; e.b = int'(Baddr); e.r = int'(Raddr); e.c = int'(Caddr);
               blog.push_back(e);
               base = lin;
               cnt = 0;
               checks++;
               if (Wr) begin
                  st = 1;
                  if (lin != exp_wptr) begin
                     errors++;
                     $display("FAIL wr_burst_addr: got %0d, required %0d", lin, exp_wptr);
                  end
               end else begin
                  st = 2;
                  if (lin != exp_rptr) begin
                     errors++;
                     $display("FAIL rd_burst_addr: got %0d, required %0d", lin, exp_rptr);
                  end
               end
            end
            if (st == 1) begin
               if (cnt < 8) begin
                  Wr_data_vaild = 1;
                  sdram_mem[base + cnt] = Wr_data;
                  cnt++;
               end else begin
                  Wr_data_vaild = 0;
                  Wdata_done = 1;
                  exp_wptr = (exp_wptr + 8) % (1 << 24);
                  st = 0;
               end
            end else if (st == 2) begin
               if (cnt < 8) begin
                  Rd_data_vaild = 1;
                  Rd_data = sdram_mem.exists(base + cnt) ? sdram_mem[base + cnt] : 16'hxxxx;
                  cnt++;
               end else begin
                  Rd_data_vaild = 0;
                  Rdata_done = 1;
                  exp_rptr = (exp_rptr + 8) % (1 << 24);
                  st = 0;
               end
            end
         end
      end
   end

   task automatic clear_model();
      exp_q.delete();
      blog.delete();
      exp_wptr = 0;
      exp_rptr = 0;
      both_seen = 0;
   endtask

   task automatic do_reset();
      Rst = 1; wr_en = 0; rd_en = 0;
      clear_model();
      repeat (3) @(negedge clk);
      clear_model();
      Rst = 0;
   endtask

   task automatic push_word(input logic [15:0] d);
      int guard = 0;
      while (wr_full && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (wr_full) begin
         checks++; errors++;
         $display("FAIL push_timeout: wr_full stuck at %0b, required 0", wr_full);
      end else begin
         wr_en = 1; wr_data = d;
         exp_q.push_back(d);
         @(negedge clk);
         wr_en = 0;
      end
   endtask

   task automatic pop_word();
      int guard = 0;
      logic [15:0] e;
      while (rd_empty && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (rd_empty) begin
         errors++;
         $display("FAIL pop_timeout: rd_empty=%0b, required 0", rd_empty);
      end else begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
         if (rd_data !== e) begin
            errors++;
            $display("FAIL pop_data: got %h, required %h", rd_data, e);
         end
         rd_en = 1;
         @(negedge clk);
         rd_en = 0;
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({Wr, Rd, wr_full, rd_empty} !== 4'b0001) begin
         errors++;
         $display("FAIL reset_flags: Wr/Rd/wr_full/rd_empty=%b, required 0001", {Wr, Rd, wr_full, rd_empty});
      end
      checks++;
      if (Baddr !== 2'd0 || Raddr !== 13'd0 || Caddr !== 13'd0) begin
         errors++;
         $display("FAIL reset_addr: b/r/c=%0d/%0d/%0d, required 0/0/0", Baddr, Raddr, Caddr);
      end
      checks++;
      if ({err_ovf, err_udf} !== 2'b00) begin
         errors++;
         $display("FAIL reset_err: err_ovf/err_udf=%b, required 00", {err_ovf, err_udf});
      end
   endtask

   task automatic test_basic();
      bit seen = 0;
      do_reset();
      for (int i = 1; i <= 8; i++) push_word(16'(i));
      for (int k = 0; k < 5 && !seen; k++) begin
         if (Wr) seen = 1; else @(negedge clk);
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL basic_wr_rise: Wr=%0b, required 1", Wr);
      end
      checks++;
      if (Baddr !== 2'd0 || Raddr !== 13'd0 || Caddr !== 13'd0) begin
         errors++;
         $display("FAIL basic_addr: b/r/c=%0d/%0d/%0d, required 0/0/0", Baddr, Raddr, Caddr);
      end
      for (int i = 1; i <= 8; i++) begin
         checks++;
         if (exp_q.size() > 0 && exp_q[0] !== 16'(i)) begin
            errors++;
            $display("FAIL basic_order: model head %h, required %h", exp_q[0], 16'(i));
         end
         pop_word();
      end
      checks++;
      if (blog.size() != 2 || !blog[0].wr || blog[1].wr) begin
         errors++;
         $display("FAIL basic_bursts: %0d bursts logged, required 2 (Wr then Rd)", blog.size());
      end
   endtask

   task automatic test_threshold();
      bit early = 0;
      bit seen = 0;
      do_reset();
      for (int i = 0; i < 7; i++) push_word(16'($urandom));
      for (int k = 0; k < 12; k++) begin
         if (Wr) early = 1;
         @(negedge clk);
      end
      checks++;
      if (early) begin
         errors++;
         $display("FAIL thresh_7: Wr rose with 7 words, required 0");
      end
      push_word(16'($urandom));
      for (int k = 0; k < 2 && !seen; k++) begin
         if (Wr) seen = 1; else @(negedge clk);
      end
      if (!seen && Wr) seen = 1;
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL thresh_8: Wr=%0b within 2 cycles, required 1", Wr);
      end
      for (int i = 0; i < 8; i++) pop_word();
   endtask

   task automatic test_priority();
      do_reset();
      for (int i = 0; i < 16; i++) push_word(16'($urandom));
      for (int i = 0; i < 16; i++) pop_word();
      checks++;
      if (blog.size() != 4) begin
         errors++;
         $display("FAIL prio_count: %0d bursts, required 4", blog.size());
      end else begin
         checks++;
         if (!(blog[0].wr && blog[1].wr && !blog[2].wr && !blog[3].wr)) begin
            errors++;
            $display("FAIL prio_order: wr flags %0d%0d%0d%0d, required 1100",
                     blog[0].wr, blog[1].wr, blog[2].wr, blog[3].wr);
         end
         checks++;
         if (blog[1].c != 8 || blog[2].c != 0 || blog[3].c != 8) begin
            errors++;
            $display("FAIL prio_cols: got %0d/%0d/%0d, required 8/0/8", blog[1].c, blog[2].c, blog[3].c);
         end
      end
      checks++;
      if (both_seen != 0) begin
         errors++;
         $display("FAIL prio_both: Wr&&Rd seen %0d times, required 0", both_seen);
      end
   endtask

   task automatic test_stream();
      int pushed = 0, popped = 0, cyc = 0, wi = 0;
      logic [15:0] d, e;
      do_reset();
      while (popped < 576 && cyc < 20000) begin
         wr_en = 0; rd_en = 0;
         if (pushed < 576 && !wr_full && ($urandom_range(3) != 0)) begin
            d = 16'($urandom);
            wr_en = 1; wr_data = d;
            exp_q.push_back(d);
            pushed++;
         end
         if (!rd_empty && ($urandom_range(2) != 0)) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            checks++;
            if (rd_data !== e) begin
               errors++;
               $display("FAIL stream_data[%0d]: got %h, required %h", popped, rd_data, e);
            end
            rd_en = 1;
            popped++;
         end
         @(negedge clk);
         cyc++;
      end
      wr_en = 0; rd_en = 0;
      checks++;
      if (popped != 576) begin
         errors++;
         $display("FAIL stream_done: popped %0d, required 576", popped);
      end
      foreach (blog[i]) begin
         if (blog[i].wr) begin
            if (wi == 63 || wi == 64) begin
               checks++;
               if (blog[i].c != ((wi == 63) ? 504 : 0) || blog[i].r != ((wi == 63) ? 0 : 1)) begin
                  errors++;
                  $display("FAIL stream_wrap[%0d]: row/col %0d/%0d, required %0d/%0d",
                           wi, blog[i].r, blog[i].c, (wi == 63) ? 0 : 1, (wi == 63) ? 504 : 0);
               end
            end
            wi++;
         end
      end
      checks++;
      if (wi != 72 || both_seen != 0) begin
         errors++;
         $display("FAIL stream_bursts: %0d writes, both=%0d, required 72 and 0", wi, both_seen);
      end
   endtask

   task automatic test_reset_mid();
      bit seen = 0;
      do_reset();
      for (int i = 0; i < 8; i++) push_word(16'($urandom));
      for (int k = 0; k < 5 && !seen; k++) begin
         if (Wr) seen = 1; else @(negedge clk);
      end
      repeat (3) @(negedge clk);
      Rst = 1;
      @(negedge clk);
      checks++;
      if ({Wr, Rd, wr_full, rd_empty} !== 4'b0001) begin
         errors++;
         $display("FAIL midrst_flags: Wr/Rd/wr_full/rd_empty=%b, required 0001", {Wr, Rd, wr_full, rd_empty});
      end
      clear_model();
      @(negedge clk);
      clear_model();
      Rst = 0;
      for (int i = 0; i < 8; i++) push_word(16'($urandom));
      for (int i = 0; i < 8; i++) pop_word();
      checks++;
      if (blog.size() < 1 || blog[0].c != 0 || blog[0].r != 0 || blog[0].b != 0) begin
         errors++;
         $display("FAIL midrst_ptr: first burst after reset not at address 0 (%0d logged)", blog.size());
      end
   endtask

   task automatic test_err();
      do_reset();
      checks++;
      if (err_udf !== 1'b0) begin
         errors++;
         $display("FAIL err_init: err_udf=%0b, required 0", err_udf);
      end
      rd_en = 1;
      @(negedge clk);
      rd_en = 0;
      @(negedge clk);
      checks++;
      if (err_udf !== ERR_EN) begin
         errors++;
         $display("FAIL err_set: err_udf=%0b, required %0b", err_udf, ERR_EN);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (err_udf !== ERR_EN || err_ovf !== 1'b0) begin
         errors++;
         $display("FAIL err_sticky: err_udf/err_ovf=%0b/%0b, required %0b/0", err_udf, err_ovf, ERR_EN);
      end
      do_reset();
      checks++;
      if (err_udf !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: err_udf=%0b, required 0", err_udf);
      end
   endtask

   initial begin
      Rst = 1; wr_en = 0; rd_en = 0; wr_data = '0;
      test_reset();
      test_basic();
      test_threshold();
      test_priority();
      test_stream();
      test_reset_mid();
      test_err();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
